t09_lcd_cmd_sequencer: RTL and testbench

- Byte-level LCD bus driver that `t09_update_controller` sequences.
- Consumes its `mode`/`wr` strobes and returns `pause`/`cmd_finished`.
- Emits HD44780-style 8-bit parallel transfers (`lcd_rs`, `lcd_en`, `lcd_data`) with enable-pulse and settle timing.
- Init commands come from an internal ROM; update traffic is a DDRAM-address command followed by characters read from the external character buffer.

---
 rtl/t09_lcd_cmd_sequencer_pkg.sv | 49 ++++
 rtl/t09_lcd_cmd_sequencer_if.sv | 23 ++
 rtl/t09_lcd_cmd_sequencer_timer.sv | 35 +++
 rtl/t09_lcd_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_t09_lcd_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/t09_lcd_cmd_sequencer_pkg.sv
// Shared constants and types for the LCD command sequencer slice:
// controller mode encoding, init command ROM, special commands, FSM states.
package t09_lcd_pkg;

    // Controller mode encoding, as presented on the mode bus.
    localparam logic [2:0] MODE_IDLE         = 3'd0;
    localparam logic [2:0] MODE_INIT_WAIT    = 3'd1;
    localparam logic [2:0] MODE_UPDATE_WAIT  = 3'd2;
    localparam logic [2:0] MODE_INIT_WRITE   = 3'd3;
    localparam logic [2:0] MODE_UPDATE_WRITE = 3'd4;
    localparam logic [2:0] MODE_DONE         = 3'd5;

    // Number of commands in the power-up init sequence.
    localparam int INIT_LEN = 4;

    // Commands with special meaning to the sequencer.
    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_DDRAM0 = 8'h80;

    // Width of the shared timing counter; must hold the longest settle.
    localparam int TIMER_W = 16;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HIGH,
        ST_HOLD
    } xfer_state_t;

    // Init ROM: 8-bit mode/2 lines, display on, entry increment, clear.
    function automatic logic [7:0] init_rom_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = CMD_CLEAR;
        endcase
        return b;
    endfunction

    // Clear and home need the long execution time on the LCD side.
    function automatic logic needs_long_settle(input logic rs, input logic [7:0] b);
        return (!rs) && ((b == CMD_CLEAR) || (b == CMD_HOME));
    endfunction

endpackage

// File: rtl/t09_lcd_cmd_sequencer_if.sv
// Controller-side handshake plus the LCD parallel bus, bundled for the
// sequencer. master = controller/bench side, slave = sequencer side.
interface t09_lcd_cmd_sequencer_if;
    logic [2:0] mode;
    logic       wr;
    logic [7:0] char_data;
    logic [3:0] char_addr;
    logic       pause;
    logic       cmd_finished;
    logic       lcd_rs;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output mode, wr, char_data,
        input  char_addr, pause, cmd_finished, lcd_rs, lcd_en, lcd_data
    );

    modport slave (
        input  mode, wr, char_data,
        output char_addr, pause, cmd_finished, lcd_rs, lcd_en, lcd_data
    );
endinterface

// File: rtl/t09_lcd_cmd_sequencer_timer.sv
// Loadable down counter; done while the count sits at zero. Loading value
// N gives N+1 cycles until done is seen in the cycle after the load.
module t09_lcd_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/t09_lcd_cmd_sequencer.sv
// Byte-level HD44780-style bus driver. Each accepted wr produces one
// SETUP / EN_HIGH / HOLD transfer; index walks through the init ROM or the
// DDRAM-address-then-characters update pass.
module t09_lcd_cmd_sequencer
    import t09_lcd_pkg::*;
#(
    parameter int EN_CYCLES          = 20,
    parameter int SETTLE_CYCLES      = 40,
    parameter int LONG_SETTLE_CYCLES = 2000,
    parameter int NUM_CHARS          = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    t09_lcd_cmd_sequencer_if.slave   bus
);
    xfer_state_t          state_q;
    logic [4:0]           index_q;
    logic [4:0]           index_d;
    logic [TIMER_W-1:0]   settle_q;
    logic [7:0]           lcd_data_q;
    logic                 lcd_rs_q;
    logic                 lcd_en_q;
    logic                 pause_q;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_done;

    logic                 mode_clears;
    logic                 accept;
    logic                 hold_done;
    logic [7:0]           sel_byte;
    logic                 sel_rs;

    assign mode_clears = (bus.mode == MODE_IDLE) || (bus.mode == MODE_DONE);
    assign accept      = bus.wr && (state_q == ST_IDLE) &&
                         ((bus.mode == MODE_INIT_WRITE) || (bus.mode == MODE_UPDATE_WRITE));
    assign hold_done   = (state_q == ST_HOLD) && timer_done;

    // Pick the byte for the next transfer from the ROM, the DDRAM address
    // command, or the character buffer.
    always_comb begin
        sel_byte = CMD_DDRAM0;
        sel_rs   = 1'b0;
        if (bus.mode == MODE_INIT_WRITE) begin
            sel_byte = init_rom_byte(index_q[1:0]);
        end else if (index_q != 5'd0) begin
            sel_byte = bus.char_data;
            sel_rs   = 1'b1;
        end
    end

    // Timer reload points: EN width on leaving SETUP, settle on leaving EN_HIGH.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state_q == ST_SETUP) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(EN_CYCLES - 1);
        end else if ((state_q == ST_EN_HIGH) && timer_done) begin
            timer_load  = 1'b1;
            timer_value = settle_q;
        end
    end

    // Pass position: mode clear has priority over the end-of-transfer step,
    // and the count saturates rather than wrapping.
    always_comb begin
        index_d = index_q;
        if (mode_clears) begin
            index_d = '0;
        end else if (hold_done && (index_q != 5'd31)) begin
            index_d = index_q + 5'd1;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    // Transfer FSM with registered bus outputs and pause.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_SETUP;
                        lcd_data_q <= sel_byte;
                        lcd_rs_q   <= sel_rs;
                        settle_q   <= needs_long_settle(sel_rs, sel_byte) ?
                                      TIMER_W'(LONG_SETTLE_CYCLES - 1) :
                                      TIMER_W'(SETTLE_CYCLES - 1);
                        pause_q    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q  <= ST_EN_HIGH;
                    lcd_en_q <= 1'b1;
                end
                ST_EN_HIGH: begin
                    if (timer_done) begin
                        state_q  <= ST_HOLD;
                        lcd_en_q <= 1'b0;
                    end
                end
                default: begin
                    if (timer_done) begin
                        state_q <= ST_IDLE;
                        pause_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    t09_lcd_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk   (clk),
        .nrst  (nrst),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    assign bus.char_addr    = (index_q == 5'd0) ? 4'd0 : (index_q[3:0] - 4'd1);
    assign bus.cmd_finished = ((bus.mode == MODE_INIT_WRITE)   && (index_q == 5'(INIT_LEN - 1))) ||
                              ((bus.mode == MODE_UPDATE_WRITE) && (index_q == 5'(NUM_CHARS)));
    assign bus.pause        = pause_q;
    assign bus.lcd_rs       = lcd_rs_q;
    assign bus.lcd_en       = lcd_en_q;
    assign bus.lcd_data     = lcd_data_q;
endmodule

// File: tb/tb_t09_lcd_cmd_sequencer.sv
// Scoreboard bench: the driver plays controller, predicts each transfer from
// the pass contents and pushes it; a negedge monitor measures what appears
// on the LCD bus and compares against the queue head.
module tb_t09_lcd_cmd_sequencer;
    localparam int EN   = 2;
    localparam int SET  = 3;
    localparam int LONG = 10;
    localparam int NCH  = 16;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         settle;
        int         wr_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_xfer = 0;
    int   m_idx = 0;
    logic [7:0] cbuf [NCH];
    exp_t sb_q [$];

    t09_lcd_cmd_sequencer_if bus ();

    t09_lcd_cmd_sequencer #(
        .EN_CYCLES          (EN),
        .SETTLE_CYCLES      (SET),
        .LONG_SETTLE_CYCLES (LONG),
        .NUM_CHARS          (NCH)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    assign bus.char_data = cbuf[bus.char_addr];

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [7:0] rom(input int i);
        case (i)
            0: return 8'h38;
            1: return 8'h0C;
            2: return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Monitor: measure each pause window and compare with the queue head.
    initial begin
        logic prev_pause = 1'b0;
        logic in_x = 1'b0;
        int pcnt = 0, ecnt = 0, scnt = 0, first_en = 0;
        logic [7:0] cap_d = '0;
        logic cap_rs = 1'b0;
        logic stable = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_pause = 1'b0;
                in_x = 1'b0;
            end else begin
                if (bus.pause && !prev_pause) begin
                    in_x = 1'b1; pcnt = 0; ecnt = 0; scnt = 0; first_en = -1; stable = 1'b1;
                end
                if (in_x && bus.pause) begin
                    pcnt++;
                    if (bus.lcd_en) begin
                        if (ecnt == 0) begin
                            first_en = cyc; cap_d = bus.lcd_data; cap_rs = bus.lcd_rs;
                        end
                        if (scnt != 0) stable = 1'b0;
                        ecnt++;
                    end else if (ecnt > 0) begin
                        scnt++;
                    end
                    if (ecnt > 0 && (bus.lcd_data !== cap_d || bus.lcd_rs !== cap_rs)) stable = 1'b0;
                end
                if (in_x && !bus.pause && prev_pause) begin
                    in_x = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_transfer", 32'(cap_d), 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        n_xfer++;
                        $display("xfer %0d: data=0x%02h rs=%0d en=%0d settle=%0d pause=%0d",
                                 n_xfer, cap_d, cap_rs, ecnt, scnt, pcnt);
                        chk("lcd_data", 32'(cap_d), 32'(e.data));
                        chk("lcd_rs", 32'(cap_rs), 32'(e.rs));
                        chk("en_delay", 32'(first_en - e.wr_cyc), 32'd2);
                        chk("en_cycles", 32'(ecnt), 32'(EN));
                        chk("settle_cycles", 32'(scnt), 32'(e.settle));
                        chk("pause_cycles", 32'(pcnt), 32'(1 + EN + e.settle));
                        chk("bus_stable", 32'(stable), 32'd1);
                    end
                end
                prev_pause = bus.pause;
            end
        end
    end

    task automatic set_mode(input logic [2:0] m);
        @(posedge clk); #1;
        bus.mode = m;
        if (m == 3'd0 || m == 3'd5) m_idx = 0;
        @(posedge clk); #1;
    endtask

    // variant: 0 plain, 1 extra wr during EN_HIGH, 2 mode->0 during EN_HIGH,
    // 3 reset during EN_HIGH.
    task automatic do_write(input logic [2:0] wmode, input int variant);
        exp_t e;
        logic [7:0] eb;
        logic ers, efin;
        int budget;
        @(posedge clk); #1;
        bus.mode = wmode;
        #1;
        if (wmode == 3'd3) begin
            eb = rom(m_idx); ers = 1'b0; efin = (m_idx == 3);
        end else begin
            eb = (m_idx == 0) ? 8'h80 : cbuf[m_idx - 1];
            ers = (m_idx != 0); efin = (m_idx == NCH);
        end
        chk("cmd_finished", 32'(bus.cmd_finished), 32'(efin));
        chk("char_addr", 32'(bus.char_addr), (m_idx == 0) ? 32'd0 : 32'(m_idx - 1));
        bus.wr = 1'b1;
        e.data = eb; e.rs = ers; e.wr_cyc = cyc;
        e.settle = (!ers && (eb == 8'h01 || eb == 8'h02)) ? LONG : SET;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.wr = 1'b0;
        bus.mode = (wmode == 3'd3) ? 3'd1 : 3'd2;
        if (variant != 0) begin
            budget = 20;
            while (!bus.lcd_en && budget > 0) begin
                @(posedge clk); #1; budget--;
            end
            if (budget == 0) chk("en_timeout", 32'(bus.lcd_en), 32'd1);
            if (variant == 1) begin
                bus.mode = wmode; bus.wr = 1'b1;
                @(posedge clk); #1;
                bus.wr = 1'b0; bus.mode = (wmode == 3'd3) ? 3'd1 : 3'd2;
            end else if (variant == 2) begin
                bus.mode = 3'd0; m_idx = 0;
            end else begin
                #1 nrst = 1'b0;
                #1;
                chk("rst_lcd_en", 32'(bus.lcd_en), 32'd0);
                chk("rst_pause", 32'(bus.pause), 32'd0);
                sb_q.delete();
                m_idx = 0;
                repeat (2) @(posedge clk);
                #1 nrst = 1'b1;
                chk("rst_char_addr", 32'(bus.char_addr), 32'd0);
                return;
            end
        end
        budget = 3000;
        while (bus.pause && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        if (budget == 0) chk("pause_timeout", 32'(bus.pause), 32'd0);
        if (bus.mode == 3'd0 || bus.mode == 3'd5) m_idx = 0;
        else if (m_idx < 31) m_idx++;
    endtask

    task automatic init_pass(input int abuse_at);
        for (int i = 0; i < 4; i++) do_write(3'd3, (i == abuse_at) ? 1 : 0);
        set_mode(3'd5);
    endtask

    task automatic update_pass(input int abuse_at);
        for (int i = 0; i <= NCH; i++) do_write(3'd4, (i == abuse_at) ? 1 : 0);
        set_mode(3'd5);
    endtask

    task automatic ignored_wr(input logic [2:0] m);
        logic seen;
        @(posedge clk); #1;
        bus.mode = m;
        if (m == 3'd0) m_idx = 0;
        bus.wr = 1'b1;
        @(posedge clk); #1;
        bus.wr = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.pause || bus.lcd_en) seen = 1'b1;
        end
        chk("ignored_wr", 32'(seen), 32'd0);
    endtask

    initial begin
        string hello;
        hello = "HELLO WORLD 1234";
        for (int i = 0; i < NCH; i++) cbuf[i] = hello[i];
        bus.mode = 3'd3;
        bus.wr = 1'b0;
        #12;
        chk("reset_pause", 32'(bus.pause), 32'd0);
        chk("reset_lcd_en", 32'(bus.lcd_en), 32'd0);
        chk("reset_lcd_data", 32'(bus.lcd_data), 32'd0);
        chk("reset_lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("reset_char_addr", 32'(bus.char_addr), 32'd0);
        chk("reset_cmd_finished", 32'(bus.cmd_finished), 32'd0);
        @(posedge clk); #1 nrst = 1'b1;
        set_mode(3'd0);

        init_pass(1);
        update_pass(5);

        ignored_wr(3'd0);
        ignored_wr(3'd2);

        do_write(3'd4, 2);
        do_write(3'd4, 0);
        set_mode(3'd5);

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NCH; i++) cbuf[i] = 8'($urandom_range(32, 126));
            if (p == 1) init_pass(int'($urandom_range(0, 3)));
            update_pass(int'($urandom_range(0, NCH)));
        end

        set_mode(3'd0);
        do_write(3'd3, 0);
        do_write(3'd3, 3);
        do_write(3'd4, 0);
        set_mode(3'd0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
